// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: zero-fills every register after reset or clear_i, then
// round-robin shares the write port. Define REGFILE_ARB_PERF_EN to add per-requester stall counters.
module regfile_wr_arbiter #(
   parameter int unsigned NR_REQ     = 3,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DROP_X0    = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 clear_i,
   input  logic [NR_REQ-1:0]                    req_valid_i,
   output logic [NR_REQ-1:0]                    req_ready_o,
   input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]    req_data_i,
   output logic                                 rf_we_o,
   output logic [ADDR_WIDTH-1:0]                rf_waddr_o,
   output logic [DATA_WIDTH-1:0]                rf_wdata_o,
   output logic                                 clear_done_o,
`ifdef REGFILE_ARB_PERF_EN
   output logic [NR_REQ-1:0][15:0]              stall_cnt_o,
`endif
   output logic                                 busy_o
);

   localparam int unsigned PtrW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   typedef enum logic {StClear, StRun} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  found_hi, found_any, hs;
   logic [PtrW-1:0]       win_hi, win_any, win;
   logic [NR_REQ-1:0]     ready;

   // Rotating priority: lowest valid index at or above the pointer, else lowest valid overall.
   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      win_hi    = '0;
      win_any   = '0;
      for (int j = NR_REQ - 1; j >= 0; j--) begin
         if (req_valid_i[j]) begin
            found_any = 1'b1;
            win_any   = PtrW'(j);
            if (j >= int'(ptr_q)) begin
               found_hi = 1'b1;
               win_hi   = PtrW'(j);
            end
         end
      end
      win   = found_hi ? win_hi : win_any;
      hs    = (state_q == StRun) && found_any;
      ready = '0;
      if (hs) begin
         ready[win] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      case (state_q)
         StClear: begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if (clear_i) begin
               cnt_d = '0;
            end else if (cnt_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (hs) begin
               we_d    = !((DROP_X0 != 0) && (req_addr_i[win] == '0));
               waddr_d = req_addr_i[win];
               wdata_d = req_data_i[win];
               ptr_d   = (win == PtrW'(NR_REQ - 1)) ? '0 : win + 1'b1;
            end
            // A same-cycle grant still lands; the zero-fill follows it.
            if (clear_i) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StClear;
         cnt_q   <= '0;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef REGFILE_ARB_PERF_EN
   logic [NR_REQ-1:0][15:0] stall_q;

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_REQ; i++) begin
         if (!rst_ni || clear_i) begin
            stall_q[i] <= '0;
         end else if ((state_q == StRun) && req_valid_i[i] && !ready[i] && (stall_q[i] != '1)) begin
            stall_q[i] <= stall_q[i] + 16'd1;
         end
      end
   end

   assign stall_cnt_o = stall_q;
`endif

   assign req_ready_o  = ready;
   assign rf_we_o      = we_q;
   assign rf_waddr_o   = waddr_q;
   assign rf_wdata_o   = wdata_q;
   assign clear_done_o = (state_q == StRun);
   assign busy_o       = (state_q == StClear);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: zero-fill, single/rotating grants, x0 drop, clear, reset.
module tb_regfile_wr_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic [2:0]       req_valid;
   logic [2:0]       req_ready;
   logic [2:0][4:0]  req_addr;
   logic [2:0][63:0] req_data;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [63:0]      rf_wdata;
   logic             clear_done;
   logic             busy;
`ifdef REGFILE_ARB_PERF_EN
   logic [2:0][15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   regfile_wr_arbiter dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_data_i   (req_data),
      .rf_we_o      (rf_we),
      .rf_waddr_o   (rf_waddr),
      .rf_wdata_o   (rf_wdata),
      .clear_done_o (clear_done),
`ifdef REGFILE_ARB_PERF_EN
      .stall_cnt_o  (stall_cnt),
`endif
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      step();
      step();
      check_eq("rst_we", rf_we, 0);
      check_eq("rst_waddr", rf_waddr, 0);
      check_eq("rst_wdata", rf_wdata, 0);
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_done", clear_done, 0);
      check_eq("rst_busy", busy, 1);

      // Zero-fill after reset release.
      rst_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         step();
         check_eq("clr_we", rf_we, 1);
         check_eq("clr_waddr", rf_waddr, k);
         check_eq("clr_wdata", rf_wdata, 0);
      end
      check_eq("clr_done", clear_done, 1);
      check_eq("clr_busy", busy, 0);
      step();
      check_eq("idle_we", rf_we, 0);

      // Single requester 1 (pointer 0 -> 2).
      req_valid   = 3'b010;
      req_addr[1] = 5'd5;
      req_data[1] = 64'hDEADBEEF_00000001;
      settle();
      check_eq("r1_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      check_eq("r1_we", rf_we, 1);
      check_eq("r1_waddr", rf_waddr, 5);
      check_eq("r1_wdata", rf_wdata, 64'hDEADBEEF_00000001);
      step();
      check_eq("hold_we", rf_we, 0);
      check_eq("hold_waddr", rf_waddr, 5);

      // Requester 2 alone brings the pointer back to 0.
      req_valid   = 3'b100;
      req_addr[2] = 5'd7;
      req_data[2] = 64'h77;
      settle();
      check_eq("r2_ready", req_ready, 3'b100);
      step();
      check_eq("r2_waddr", rf_waddr, 7);

      // All three continuously valid: 0,1,2,0,1,2.
      req_valid = 3'b111;
      for (int r = 0; r < 3; r++) begin
         req_addr[r] = 5'(10 + r);
         req_data[r] = 64'h1000 + 64'(r);
      end
      for (int k = 0; k < 6; k++) begin
         settle();
         check_eq("rr_ready", req_ready, 64'(1) << (k % 3));
         step();
         check_eq("rr_we", rf_we, 1);
         check_eq("rr_waddr", rf_waddr, 10 + (k % 3));
         check_eq("rr_wdata", rf_wdata, 64'h1000 + 64'(k % 3));
      end
      req_valid = '0;

      // Write to x0 is accepted but dropped; pointer still advances to 1.
      req_valid   = 3'b001;
      req_addr[0] = 5'd0;
      req_data[0] = 64'hABCD;
      settle();
      check_eq("x0_ready", req_ready, 3'b001);
      step();
      check_eq("x0_we", rf_we, 0);
      req_valid   = 3'b011;
      req_addr[1] = 5'd3;
      settle();
      check_eq("x0_ptr", req_ready, 3'b010);
      step();
      req_valid = '0;
      check_eq("x0_next_waddr", rf_waddr, 3);

      // clear_i together with a grant to requester 2 (pointer 2).
      req_valid   = 3'b100;
      req_addr[2] = 5'd9;
      req_data[2] = 64'h9999;
      clear       = 1'b1;
      settle();
      check_eq("cg_ready", req_ready, 3'b100);
      step();
      clear       = 1'b0;
      req_valid   = 3'b010;
      req_addr[1] = 5'd4;
      req_data[1] = 64'h4444;
      check_eq("cg_we", rf_we, 1);
      check_eq("cg_waddr", rf_waddr, 9);
      check_eq("cg_wdata", rf_wdata, 64'h9999);
      check_eq("cg_done", clear_done, 0);
      check_eq("cg_busy", busy, 1);
      for (int k = 0; k < 32; k++) begin
         settle();
         check_eq("cg_held_ready", req_ready, 0);
         step();
         check_eq("cg_clr_waddr", rf_waddr, k);
         check_eq("cg_clr_wdata", rf_wdata, 0);
         check_eq("cg_clr_we", rf_we, 1);
      end
      check_eq("cg_done_end", clear_done, 1);
      settle();
      check_eq("cg_r1_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      check_eq("cg_r1_waddr", rf_waddr, 4);

`ifdef REGFILE_ARB_PERF_EN
      // Pointer is 2: grant r2 alone to return to 0, then let r2 stall twice.
      req_valid = 3'b100;
      step();
      req_valid = 3'b111;
      step();
      step();
      settle();
      check_eq("perf_ready", req_ready, 3'b100);
      check_eq("perf_stall2", stall_cnt[2], 2);
      check_eq("perf_stall1", stall_cnt[1], 1);
      step();
      req_valid = '0;
`endif

      // Reset in the middle of a zero-fill.
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("rm_we0", rf_we, 0);
      for (int k = 0; k < 10; k++) begin
         step();
      end
      check_eq("rm_waddr9", rf_waddr, 9);
      rst_n = 1'b0;
      step();
      check_eq("rm_we", rf_we, 0);
      check_eq("rm_waddr", rf_waddr, 0);
      check_eq("rm_busy", busy, 1);
      rst_n = 1'b1;
      step();
      check_eq("rm_restart_we", rf_we, 1);
      check_eq("rm_restart_waddr", rf_waddr, 0);
      step();
      check_eq("rm_restart_waddr1", rf_waddr, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port among NR_REQ independent writers, e.g. commit, debug module and CSR-side restore.
- Performs a hardware clear sequence that writes zero to every register after reset or on request, then round-robin arbitrates writers.
- Sits between the writers and the flip-flop register file's write port (waddr/wdata/we).
- Output write is registered, so register-file timing is independent of requester logic.

Parameters:
- NR_REQ, 3, number of write requesters (2..8)
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH
- DROP_X0, 1, when 1, requests to address 0 are accepted but never drive a write

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- clear_i  in  1  single-cycle pulse that restarts the clear sequence
- req_valid_i  in  NR_REQ  per-requester write request
- req_ready_o  out  NR_REQ  per-requester accept
- req_addr_i  in  NR_REQ x ADDR_WIDTH  target register
- req_data_i  in  NR_REQ x DATA_WIDTH  write data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  ADDR_WIDTH  register-file write address
- rf_wdata_o  out  DATA_WIDTH  register-file write data
- clear_done_o  out  1  high once the clear sequence has completed
- busy_o  out  1  high while in CLEAR

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=CLEAR, clear counter=0, round-robin pointer=0.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - req_ready_o=0, clear_done_o=0, busy_o=1.
- FSM has two states: CLEAR and RUN.
- CLEAR:
  - Each cycle, register rf_we_o=1, rf_waddr_o=counter, rf_wdata_o=0.
  - Counter increments by 1.
  - After the write to NUM_WORDS-1 (32 writes, cycles 1..32 after reset release), go to RUN.
  - req_ready_o is all 0 throughout; requests are held, not dropped.
- RUN:
  - busy_o=0. clear_done_o=1 and stays 1 until the next reset or clear_i.
  - Grant goes to the first requester with valid=1, searching from pointer upward with wrap modulo NR_REQ.
  - req_ready_o is one-hot on the winner, combinational from req_valid_i and the pointer. It is all 0 if nobody is valid.
  - A handshake is valid&ready. On the next edge, rf_we_o/rf_waddr_o/rf_wdata_o take the winner's request. Latency is 1 cycle.
  - The pointer becomes winner+1, wrapping after NR_REQ-1. It is unchanged when nothing is granted.
  - No handshake in a cycle gives rf_we_o=0 the next cycle. Address and data hold their last value.
  - DROP_X0=1 and winning address 0: the handshake completes and the pointer advances, but rf_we_o=0.
  - Throughput is one write per cycle. No requester can be starved longer than NR_REQ-1 grants.
- clear_i in RUN:
  - A grant in the same cycle still completes and is written next cycle.
  - State goes to CLEAR with counter=0 and clear_done_o=0, so the first clear write follows the granted write.
- clear_i in CLEAR: counter restarts at 0.
- Reset mid-sequence: immediate return to the reset state. Any pending registered write is discarded (rf_we_o=0).
- Requester rules:
  - A requester must keep valid, addr and data stable until ready.
  - The arbiter never asserts ready to a requester without valid.

Optional Feature:
- Macro: REGFILE_ARB_PERF_EN.
- With the macro defined:
  - Extra output stall_cnt_o [NR_REQ x 16].
  - Each counter increments every RUN cycle in which that requester has valid=1 and ready=0.
  - Counters saturate at 16'hFFFF and are cleared by reset or clear_i.
- Without the macro: the port and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- Release reset, all valid=0 -> rf_we_o=1 for 32 consecutive cycles with waddr 0..31 and wdata 0; then clear_done_o=1, busy_o=0, rf_we_o=0.
- After clear, requester 1 alone writes addr 5, data 64'hDEADBEEF_00000001 -> ready[1]=1 that cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=64'hDEADBEEF_00000001.
- All 3 requesters hold valid continuously from pointer=0 -> grants follow 0,1,2,0,1,2; rf_waddr_o sequence matches each requester's address, one write per cycle.
- Requester 0 writes addr 0 with DROP_X0=1 -> ready[0]=1, pointer advances to 1, rf_we_o stays 0.
- clear_i in the same cycle as a grant of requester 2 to addr 9 -> next cycle writes addr 9, then 32 zero-writes 0..31; clear_done_o low until they finish; requester held valid during CLEAR sees ready=0.
- With REGFILE_ARB_PERF_EN, requester 2 valid while 0 and 1 also valid for 2 cycles -> stall_cnt_o[2]=2 when it is granted; rst_ni=0 mid-clear (counter=10) -> rf_we_o=0 next edge, and the sequence restarts at address 0.
